// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int          IFU_INST_W   = 32;
  // Buffer entries hold the widest supported PC; narrower configurations zero-extend.
  localparam int          IFU_PC_MAX   = 64;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_PC_MAX-1:0] pc;
    logic [IFU_INST_W-1:0] inst;
    logic                  err;
  } ifu_entry_t;

  function automatic ifu_entry_t make_entry(input logic [IFU_PC_MAX-1:0] pc,
                                            input logic [IFU_INST_W-1:0] inst,
                                            input logic                  err);
    ifu_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    e.err  = err;
    return e;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Instruction buffer between the fetch FSM and decode: power-of-two circular FIFO
// with a synchronous flush that wins over push and pop.
module ifu_fifo import ifu_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = ifu_entry_t
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 wr_data,
  output entry_t                 rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: one outstanding fetch at a time, responses queued in
// ifu_fifo for decode, redirects restart the stream and discard stale data.
module ifu_prefetch import ifu_pkg::*; #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err,
  output logic [1:0]      ifu_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e      state;
  ifu_state_e      next_state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pending_pc;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            flush;
  logic            accept;
  ifu_entry_t      wr_entry;
  ifu_entry_t      head;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) state <= ST_REQ;
    else          state <= next_state;
  end

  // A redirect never cancels an issued request; it only marks its response stale (DROP).
  always_comb begin
    next_state = state;
    unique case (state)
      ST_REQ: begin
        if (accept) next_state = redirect_valid ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid)       next_state = (mem_rsp_err && !redirect_valid) ? ST_HALT : ST_REQ;
        else if (redirect_valid) next_state = ST_DROP;
      end
      ST_DROP: begin
        if (mem_rsp_valid) next_state = ST_REQ;
      end
      ST_HALT: begin
        if (redirect_valid) next_state = ST_REQ;
      end
      default: next_state = ST_REQ;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;
    if (sys_rst) begin
      mem_req_valid = (state == ST_REQ) && (count < CW'(DEPTH));
      flush         = redirect_valid;
      push          = (state == ST_WAIT) && mem_rsp_valid && !redirect_valid && !full;
      pop           = !empty && out_ready && !redirect_valid;
    end
  end

  assign accept       = mem_req_valid && mem_req_ready;
  assign mem_req_addr = fetch_pc;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst)            fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= redirect_pc;
    else if (accept)         fetch_pc <= fetch_pc + XLEN'(4);
  end

  // The issued address is kept so the response is tagged even after fetch_pc moves on.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst)    pending_pc <= '0;
    else if (accept) pending_pc <= fetch_pc;
  end

  assign wr_entry = make_entry(IFU_PC_MAX'(pending_pc), mem_rsp_data, mem_rsp_err);

  ifu_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (ifu_entry_t)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign out_valid = sys_rst && !empty;
  assign out_inst  = out_valid ? head.inst : '0;
  assign out_pc    = out_valid ? head.pc[XLEN-1:0] : '0;
  assign out_err   = out_valid && head.err;
  assign ifu_state = sys_rst ? state : ST_REQ;

  if (XLEN < IFU_PC_MAX) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = |head.pc[IFU_PC_MAX-1:XLEN];
  end

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of all PC and address signals.
REQ-002 Parameter DEPTH, default 4, SHALL set the instruction-buffer entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 32'h80000000, SHALL set the first fetch address after reset.
REQ-004 sys_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 sys_rst  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 redirect_valid  in  1  SHALL request a fetch-stream restart (branch/trap).
REQ-007 redirect_pc  in  XLEN  SHALL give the restart address; sampled only when redirect_valid=1.
REQ-008 mem_req_valid  out  1  SHALL flag a valid fetch request.
REQ-009 mem_req_addr  out  XLEN  SHALL carry the fetch address.
REQ-010 mem_req_ready  in  1  SHALL accept the request when high with mem_req_valid.
REQ-011 mem_rsp_valid  in  1  SHALL flag a returned instruction word.
REQ-012 mem_rsp_data  in  32  SHALL carry the instruction word.
REQ-013 mem_rsp_err  in  1  SHALL flag an access fault for the response.
REQ-014 out_valid / out_ready  out/in  1/1  SHALL form the instruction handshake to decode.
REQ-015 out_inst / out_pc / out_err  out  32/XLEN/1  SHALL carry the buffer-head entry.
REQ-016 ifu_state  out  2  SHALL expose the FSM state: REQ=0, WAIT=1, DROP=2, HALT=3.

Function
REQ-017 fetch_pc register SHALL drive mem_req_addr and advance by 4 (mod 2^XLEN) on each accepted request.
REQ-018 At most one request SHALL be outstanding.
REQ-019 mem_req_valid SHALL equal (state==REQ) && (buffer count < DEPTH); addr stable while valid && !ready.
REQ-020 REQ: acceptance -> WAIT; acceptance with redirect_valid in the same cycle -> DROP.
REQ-021 WAIT: mem_rsp_valid pushes {pc, data, err}; next state REQ, or HALT if mem_rsp_err=1.
REQ-022 WAIT with redirect_valid and no response -> DROP; with response the same cycle -> response discarded, REQ.
REQ-023 DROP: the next response SHALL be discarded, never pushed; -> REQ (a further redirect only updates fetch_pc).
REQ-024 HALT: no requests; only redirect_valid leaves HALT, to REQ.
REQ-025 redirect_valid SHALL, in every state, load fetch_pc <= redirect_pc and empty the buffer; a pop that cycle is ignored.
REQ-026 Buffer FIFO: push/pop same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH; push when full cannot occur (guaranteed by REQ-019).
REQ-027 out_valid SHALL equal (count != 0); out_* SHALL show the head entry; pop on out_valid && out_ready.
REQ-028 Latency: response in cycle T SHALL give out_valid at T+1 when the buffer was empty; no bypass path.
REQ-029 Entries SHALL leave in fetch order, with out_pc equal to the request address that produced them.
REQ-030 mem_rsp_valid outside WAIT/DROP SHALL be ignored.

Reset
REQ-031 sys_rst=0 at a clock edge SHALL set state=REQ, fetch_pc=RESET_PC, buffer empty; overrides redirect.
REQ-032 During reset: out_valid=0, mem_req_valid=0, ifu_state=0, out_inst=0, out_pc=0, out_err=0.
REQ-033 Reset mid-transaction SHALL drop the outstanding request; a late response arrives in REQ and is ignored (REQ-030).

Structure
REQ-034 Package ifu_pkg SHALL hold the state enum, the buffer-entry struct {pc, inst, err} and the RESET_PC default.
REQ-035 The buffer SHALL be the sub-module ifu_fifo (parameters DEPTH and entry type; ports push, pop, flush, full, empty, count).
REQ-036 The FSM and fetch_pc SHALL stay in ifu_prefetch.

Verification
REQ-037 Reset, ready=1, 1-cycle memory, out_ready=1 -> out_pc 0x80000000, 0x80000004, 0x80000008 in order, correct data.
REQ-038 out_ready=0, DEPTH=4 -> exactly 4 entries buffered, mem_req_valid=0 and state REQ; one pop -> one new request.
REQ-039 Redirect to 0x80001000 in WAIT -> DROP; stale response discarded; next out_pc=0x80001000; buffer empty after the redirect.
REQ-040 Redirect in the same cycle as mem_rsp_valid -> response discarded, state REQ, next request addr = redirect_pc.
REQ-041 mem_rsp_err=1 at 0x80000008 -> entry with out_err=1 delivered, state HALT, no requests; redirect -> REQ.
REQ-042 fetch_pc=0xFFFFFFFC accepted -> next addr 0x00000000; reset asserted in WAIT -> state REQ, addr 0x80000000, late response ignored.
